// File: rtl/int_ack_pkg.sv
// Shared definitions for the external-interrupt acknowledge responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package int_ack_pkg;

  // Handshake state: waiting for a request, request presented to CP0,
  // or acknowledged in level mode while the environment still holds irq_in.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    WAIT = 2'd2
  } state_e;

  // Word offsets inside the 16-byte register window.
  localparam logic [1:0] OFF_ACK  = 2'd0;
  localparam logic [1:0] OFF_CTRL = 2'd1;
  localparam logic [1:0] OFF_CNT  = 2'd2;

  // CTRL register bit positions.
  localparam int EN      = 0;
  localparam int MODE    = 1;
  localparam int OVF_CLR = 31;

endpackage

// File: rtl/int_sync2.sv
// Two-flop synchronizer for the external interrupt request, or a plain
// wire when SYNC_EN = 0. Latency: 2 cycles when enabled, 0 when bypassed.
// Backpressure: none (single-bit level signal).
// Ports: clk, rst_n (async active-low), d (async input), q (synchronized output).
module int_sync2 #(
  parameter bit SYNC_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  // The flops stay in the bypass build so both configurations share one netlist shape.
  assign q = SYNC_EN ? sync_q[1] : d;

endmodule

// File: rtl/int_ack_responder.sv
// Memory-mapped interrupt latch at BASE_ADDR: presents irq_in to CP0 as irq_out,
// cleared by a store to the ACK word, and counts serviced interrupts.
// Latency: irq_out rises 1 cycle after the triggering irq_in sample (3 with
// INT_ACK_SYNC_EN defined) and falls 1 cycle after the ACK store.
// Backpressure: none; every bus access completes in the cycle it is presented.
// Ports: clk, reset (async active-low), irq_in, addr/byteen/wdata (bridge store),
//        rdata (combinational read), irq_out (HWInt[2]), ack_pulse, ovf.
// Build option: define INT_ACK_SYNC_EN to pass irq_in through a 2-flop synchronizer.
module int_ack_responder
  import int_ack_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7f20,
  parameter int          CNT_W     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        irq_in,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq_out,
  output logic        ack_pulse,
  output logic        ovf
);

`ifdef INT_ACK_SYNC_EN
  localparam bit SYNC_EN = 1'b1;
`else
  localparam bit SYNC_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             irq_prev_q, irq_prev_d;
  logic             en_q, en_d;
  logic             mode_q, mode_d;
  logic             ovf_q, ovf_d;
  logic             ack_pulse_q, ack_pulse_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic       irq_s;
  logic       sel, wr;
  logic [1:0] off;
  logic       ack_wr, ctrl_wr, cnt_wr;
  logic       trig;
  logic       ack_ok;
  logic       unused_bits;

  int_sync2 #(.SYNC_EN(SYNC_EN)) u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (irq_in),
    .q     (irq_s)
  );

  // Bus decode
  assign sel     = (addr[31:4] == BASE_ADDR[31:4]);
  assign wr      = sel & (|byteen);
  assign off     = addr[3:2];
  assign ack_wr  = wr & (off == OFF_ACK);
  assign ctrl_wr = wr & (off == OFF_CTRL);
  assign cnt_wr  = wr & (off == OFF_CNT);
  assign unused_bits = ^{addr[1:0], wdata[30:2]};

  // Trigger uses the registered mode, so a mode change takes effect next cycle.
  assign trig   = mode_q ? (irq_s & ~irq_prev_q) : irq_s;
  assign ack_ok = ack_wr & (state_q == PEND);

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (en_q && trig) state_d = PEND;
      PEND: begin
        if (ack_ok) begin
          if (!mode_q)   state_d = WAIT;
          else if (trig) state_d = PEND;  // edge landed with the ACK: serve it next
          else           state_d = IDLE;
        end
      end
      WAIT: if (!irq_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs (disable masks a pending request without dropping it)
  always_comb begin
    irq_out = (state_q == PEND) & en_q;
  end

  // Datapath next-state
  always_comb begin
    irq_prev_d  = irq_s;
    en_d        = en_q;
    mode_d      = mode_q;
    ack_pulse_d = ack_ok;
    count_d     = count_q;
    ovf_d       = ovf_q;

    if (ctrl_wr && byteen[0]) begin
      en_d   = wdata[EN];
      mode_d = wdata[MODE];
    end

    if (cnt_wr) begin
      count_d = '0;
    end else if (ack_ok && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end

    if (ctrl_wr && byteen[3] && wdata[OVF_CLR]) begin
      ovf_d = 1'b0;
    end
    // A second edge while the first is still unacknowledged is an overrun.
    if (mode_q && (state_q == PEND) && trig && !ack_wr) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_prev_q  <= 1'b0;
      en_q        <= 1'b1;
      mode_q      <= 1'b0;
      ovf_q       <= 1'b0;
      ack_pulse_q <= 1'b0;
      count_q     <= '0;
    end else begin
      irq_prev_q  <= irq_prev_d;
      en_q        <= en_d;
      mode_q      <= mode_d;
      ovf_q       <= ovf_d;
      ack_pulse_q <= ack_pulse_d;
      count_q     <= count_d;
    end
  end

  assign ack_pulse = ack_pulse_q;
  assign ovf       = ovf_q;

  // Read mux
  always_comb begin
    rdata = 32'h0;
    if (sel) begin
      unique case (off)
        OFF_ACK:  rdata = {29'b0, ovf_q, en_q, (state_q == PEND)};
        OFF_CTRL: rdata = {30'b0, mode_q, en_q};
        OFF_CNT:  rdata[CNT_W-1:0] = count_q;
        default:  rdata = 32'h0;
      endcase
    end
  end

endmodule
